// File: rtl/seq_sub16_if.sv
// Request/result bundle for seq_sub16; ovf exists only when SEQ_SUB16_OVF_EN is defined.
interface seq_sub16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        ready;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SEQ_SUB16_OVF_EN
  logic        ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SEQ_SUB16_OVF_EN
    input  ovf,
`endif
    input  ready, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SEQ_SUB16_OVF_EN
    output ovf,
`endif
    output ready, done, diff, bout
  );
endinterface

// File: rtl/seq_sub16.sv
// Nibble-serial 16-bit subtractor a-b-bin with lookahead borrow inside each nibble (ovf under SEQ_SUB16_OVF_EN).
// Latency: done in the cycle after the 5th edge counting the accepting edge; issue interval 6 cycles.
// Backpressure: start is taken only while ready=1, otherwise ignored.
module seq_sub16 (
  input logic        clk,
  input logic        rst_n,
  seq_sub16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q, b_q, acc_q, diff_q;
  logic        borrow_q, bout_q;
  logic [1:0]  idx_q;
  logic [3:0]  na, nb, g, p, nd;
  logic [4:0]  c;
  logic        accept;
`ifdef SEQ_SUB16_OVF_EN
  logic        ovf_q;
`endif

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (idx_q == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.done  = (state == DONE);
  end

  // Current nibble; each borrow is a flat sum-of-products of g, p and the nibble borrow-in.
  assign na = a_q[{idx_q, 2'b00} +: 4];
  assign nb = b_q[{idx_q, 2'b00} +: 4];
  assign g  = ~na & nb;
  assign p  = ~(na ^ nb);
  assign c[0] = borrow_q;
  assign c[1] = g[0] | (p[0] & borrow_q);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_q);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & borrow_q);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & borrow_q);
  assign nd = na ^ nb ^ c[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SEQ_SUB16_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      borrow_q <= bus.bin;
      idx_q    <= '0;
      acc_q    <= '0;
    end else if (state == RUN) begin
      acc_q[{idx_q, 2'b00} +: 4] <= nd;
      borrow_q <= c[4];
      idx_q    <= idx_q + 2'd1;
      // Visible results update only here, so partial sums never reach the outputs.
      if (idx_q == 2'd3) begin
        diff_q <= {nd, acc_q[11:0]};
        bout_q <= c[4];
`ifdef SEQ_SUB16_OVF_EN
        ovf_q  <= (a_q[15] ^ b_q[15]) & (a_q[15] ^ nd[3]);
`endif
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SEQ_SUB16_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: doc/seq_sub16.md
SEQ_SUB16 -- requirements
Module: seq_sub16

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a subtraction; sampled only while ready=1.
REQ-004 SHALL have port a, input, 16, minuend; captured on accepted start.
REQ-005 SHALL have port b, input, 16, subtrahend; captured on accepted start.
REQ-006 SHALL have port bin, input, 1, borrow-in; captured on accepted start.
REQ-007 SHALL have port ready, output, 1, high only in IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-009 SHALL have port diff, output, 16, result a-b-bin modulo 2^16.
REQ-010 SHALL have port bout, output, 1, borrow-out; 1 iff a < b+bin as unsigned.
REQ-011 SHALL have port ovf, output, 1, signed overflow; present only under SEQ_SUB16_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b, bin, clear nibble index to 0, and go to RUN.
REQ-014 RUN: each edge SHALL compute one 4-bit nibble, lowest first, using nibble-local borrow lookahead.
REQ-015 Per bit: g=~a&b, p=~(a^b), d=a^b^borrow. Within a nibble each borrow SHALL be a flat sum-of-products of g, p and the nibble borrow-in, with no ripple.
REQ-016 The nibble borrow-out SHALL be registered and used as the next nibble's borrow-in; the first nibble SHALL use captured bin.
REQ-017 After the 4th RUN edge (index 3), the FSM SHALL load diff/bout (and ovf) from the internal accumulator and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-019 Latency: done SHALL be high in the cycle after the 5th rising edge, counting the edge that accepts start as edge 1.
REQ-020 Minimum issue interval SHALL be 6 cycles; back-to-back start is accepted at the first edge with ready=1.
REQ-021 start SHALL be ignored in RUN and DONE. Inputs a, b and bin SHALL be ignored outside the accepting edge.
REQ-022 diff, bout and ovf SHALL change only on entry to DONE and SHALL hold until the next completion. Partial results SHALL never be visible.
REQ-023 Wrap-around: the result SHALL be modulo 2^16, with bout reporting the unsigned borrow.

Reset
REQ-024 rst_n=0 SHALL force IDLE immediately, without waiting for clk.
REQ-025 While in reset, outputs SHALL be: ready=1, done=0, diff=0, bout=0, ovf=0.
REQ-026 rst_n=0 SHALL also clear nibble index, accumulator and captured operands.
REQ-027 Reset mid-operation SHALL abandon the subtraction with no done pulse. Outputs SHALL show reset values, not the previous result.
REQ-028 After rst_n rises, the first rising edge SHALL be able to accept start.

Configuration
REQ-029 Macro SEQ_SUB16_OVF_EN defined: port ovf exists, with ovf=(a[15]^b[15])&(a[15]^diff[15]) computed on the captured operands and updated with diff.
REQ-030 Macro SEQ_SUB16_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour SHALL be identical.

Verification
REQ-031 Reset, then start with a=0x1234, b=0x0001, bin=0 -> done at edge-5 cycle, diff=0x1233, bout=0.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
REQ-033 a=0x0010, b=0x0000, bin=1 -> diff=0x000F, bout=0; the borrow SHALL cross the nibble boundary.
REQ-034 With SEQ_SUB16_OVF_EN: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0; a=0x0005, b=0x0003 -> diff=0x0002, ovf=0.
REQ-035 Pulse start in RUN with different operands -> ignored; result is from the first operands, and exactly one done pulse occurs.
REQ-036 Assert rst_n=0 during RUN -> ready=1, diff=0 at once, no done; a new start after release yields the correct result.
